// File: rtl/ksg_multiblock_pkg.sv
// Shared constants, state encodings and the ChaCha quarter-round layer
// used by the multi-block keystream generator.
package ksg_multiblock_pkg;

    localparam int STATE_WORDS = 16;
    localparam int LOAD_WORDS  = 12;

    // "expand 32-byte k", word 0 in the low bits
    localparam logic [127:0] SIGMA = {
        32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865
    };

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // sh=0 gives the column layer, sh=1 the diagonal layer
    function automatic logic [511:0] qr_layer(input logic [511:0] s, input int sh);
        logic [31:0] x [STATE_WORDS];
        logic [31:0] a, b, c, d;
        logic [511:0] r;
        int ib, ic, id;
        for (int i = 0; i < STATE_WORDS; i++) x[i] = s[32*i +: 32];
        for (int g = 0; g < 4; g++) begin
            ib = 4 + ((g + sh) % 4);
            ic = 8 + ((g + 2 * sh) % 4);
            id = 12 + ((g + 3 * sh) % 4);
            a = x[g];
            b = x[ib];
            c = x[ic];
            d = x[id];
            a = a + b; d = rotl(d ^ a, 16);
            c = c + d; b = rotl(b ^ c, 12);
            a = a + b; d = rotl(d ^ a, 8);
            c = c + d; b = rotl(b ^ c, 7);
            x[g]  = a;
            x[ib] = b;
            x[ic] = c;
            x[id] = d;
        end
        for (int i = 0; i < STATE_WORDS; i++) r[32*i +: 32] = x[i];
        return r;
    endfunction

endpackage

// File: rtl/ksg_multiblock_if.sv
// Load stream, output stream and status bundle of the keystream generator.
interface ksg_multiblock_if #(
    parameter int NB_WIDTH = 8
);
    logic [31:0]         data_in;
    logic                valid_in;
    logic                ready_in;
    logic [NB_WIDTH-1:0] num_blocks;
    logic [511:0]        key_out;
    logic                valid_out;
    logic                ready_out;
    logic                busy;
    logic [NB_WIDTH-1:0] block_index;
    logic                ctr_wrap;

    modport master (
        output data_in, valid_in, num_blocks, ready_out,
        input  ready_in, key_out, valid_out, busy, block_index, ctr_wrap
    );

    modport slave (
        input  data_in, valid_in, num_blocks, ready_out,
        output ready_in, key_out, valid_out, busy, block_index, ctr_wrap
    );
endinterface

// File: rtl/ksg_round_stage.sv
// Combinational ChaCha round stage: one or two quarter-round layers,
// alternating column/diagonal from the given start op.
module ksg_round_stage
    import ksg_multiblock_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic [511:0] state_in,
    input  logic         start_op,
    output logic [511:0] state_out
);

    logic [511:0] lyr [ROUNDS_PER_CYCLE+1];

    assign lyr[0] = state_in;

    for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_layer
        localparam logic FLIP = logic'(k % 2);
        logic op;
        assign op = start_op ^ FLIP;
        assign lyr[k+1] = op ? qr_layer(lyr[k], 1) : qr_layer(lyr[k], 0);
    end

    assign state_out = lyr[ROUNDS_PER_CYCLE];

endmodule

// File: rtl/ksg_multiblock.sv
// ChaCha keystream generator: loads key/counter/nonce once and emits
// a run of consecutive 512-bit blocks with auto-incremented counter.
module ksg_multiblock
    import ksg_multiblock_pkg::*;
#(
    parameter int NUM_ROUNDS       = 20,
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int NB_WIDTH         = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    ksg_multiblock_if.slave   bus
);

    localparam int         NCYC = NUM_ROUNDS / ROUNDS_PER_CYCLE;
    localparam logic [4:0] LAST = 5'(NCYC);
    localparam logic [3:0] LAST_WC = 4'(LOAD_WORDS - 1);

    logic [1:0]          state;
    logic [3:0]          wc;
    logic [3:0]          slot;
    logic [4:0]          rcnt;
    logic [NB_WIDTH-1:0] nreq;
    logic [NB_WIDTH-1:0] bidx;
    logic [511:0]        init;
    logic [511:0]        work;
    logic [511:0]        next_work;
    logic [511:0]        sum;
    logic [511:0]        key;
    logic                vout;
    logic                wrap;
    logic                op;
    logic                more;
    logic [31:0]         ctr_next;

    // round index = rcnt * ROUNDS_PER_CYCLE, so only odd unroll sees rcnt[0]
    assign op = (ROUNDS_PER_CYCLE % 2 == 1) ? rcnt[0] : 1'b0;

    ksg_round_stage #(
        .ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)
    ) u_round (
        .state_in (work),
        .start_op (op),
        .state_out(next_work)
    );

    always_comb begin
        sum = '0;
        for (int i = 0; i < STATE_WORDS; i++)
            sum[32*i +: 32] = init[32*i +: 32] + work[32*i +: 32];
    end

    assign slot     = wc + 4'd4;
    assign ctr_next = init[384 +: 32] + 32'd1;
    assign more     = bidx < (nreq - NB_WIDTH'(1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_LOAD;
            wc    <= '0;
            rcnt  <= '0;
            nreq  <= NB_WIDTH'(1);
            bidx  <= '0;
            init  <= {384'd0, SIGMA};
            work  <= {384'd0, SIGMA};
            key   <= '0;
            vout  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (bus.valid_in) begin
                        init[{slot, 5'd0} +: 32] <= bus.data_in;
                        work[{slot, 5'd0} +: 32] <= bus.data_in;
                        if (wc == 4'd0) begin
                            nreq <= (bus.num_blocks == '0) ? NB_WIDTH'(1)
                                                           : bus.num_blocks;
                            wrap <= 1'b0;
                        end
                        if (wc == LAST_WC) begin
                            wc    <= '0;
                            rcnt  <= '0;
                            state <= S_ROUND;
                        end else begin
                            wc <= wc + 4'd1;
                        end
                    end
                end
                S_ROUND: begin
                    if (rcnt == LAST) begin
                        key   <= sum;
                        vout  <= 1'b1;
                        state <= S_OUT;
                    end else begin
                        work <= next_work;
                        rcnt <= rcnt + 5'd1;
                    end
                end
                S_OUT: begin
                    if (bus.ready_out) begin
                        vout <= 1'b0;
                        if (more) begin
                            init[384 +: 32] <= ctr_next;
                            work            <= {init[511:416], ctr_next, init[383:0]};
                            if (&init[384 +: 32]) wrap <= 1'b1;
                            bidx  <= bidx + NB_WIDTH'(1);
                            rcnt  <= '0;
                            state <= S_ROUND;
                        end else begin
                            work  <= init;
                            wc    <= '0;
                            bidx  <= '0;
                            state <= S_LOAD;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    assign bus.ready_in    = (state == S_LOAD);
    assign bus.busy        = (state != S_LOAD);
    assign bus.key_out     = key;
    assign bus.valid_out   = vout;
    assign bus.block_index = bidx;
    assign bus.ctr_wrap    = wrap;

endmodule

// File: tb/tb_ksg_multiblock.sv
// Directed bench for ksg_multiblock: RFC 8439 block, multi-block runs,
// backpressure, counter wrap, round-count variants and mid-run reset.
module tb_ksg_multiblock;

    localparam int NBW = 8;

    localparam logic [511:0] RFC_BLK = {
        32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
        32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
        32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
        32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110
    };

    logic           clk;
    logic           rst_n;
    logic [31:0]    data_in;
    logic           valid_in;
    logic [NBW-1:0] num_blocks;
    logic           ready_out;
    int             sel;

    int n_tests;
    int n_fail;

    ksg_multiblock_if #(.NB_WIDTH(NBW)) b0 ();
    ksg_multiblock_if #(.NB_WIDTH(NBW)) b1 ();
    ksg_multiblock_if #(.NB_WIDTH(NBW)) b2 ();

    assign b0.data_in = data_in;
    assign b1.data_in = data_in;
    assign b2.data_in = data_in;
    assign b0.valid_in = valid_in && (sel == 0);
    assign b1.valid_in = valid_in && (sel == 1);
    assign b2.valid_in = valid_in && (sel == 2);
    assign b0.num_blocks = num_blocks;
    assign b1.num_blocks = num_blocks;
    assign b2.num_blocks = num_blocks;
    assign b0.ready_out = ready_out;
    assign b1.ready_out = ready_out;
    assign b2.ready_out = ready_out;

    ksg_multiblock #(.NUM_ROUNDS(20), .ROUNDS_PER_CYCLE(1), .NB_WIDTH(NBW))
        dut0 (.clock(clk), .reset_n(rst_n), .bus(b0));
    ksg_multiblock #(.NUM_ROUNDS(8), .ROUNDS_PER_CYCLE(2), .NB_WIDTH(NBW))
        dut1 (.clock(clk), .reset_n(rst_n), .bus(b1));
    ksg_multiblock #(.NUM_ROUNDS(12), .ROUNDS_PER_CYCLE(1), .NB_WIDTH(NBW))
        dut2 (.clock(clk), .reset_n(rst_n), .bus(b2));

    logic [511:0]   key_s;
    logic           vo_s, rdy_s, busy_s, wrap_s;
    logic [NBW-1:0] bidx_s;

    always_comb begin
        key_s  = b0.key_out;
        vo_s   = b0.valid_out;
        rdy_s  = b0.ready_in;
        busy_s = b0.busy;
        wrap_s = b0.ctr_wrap;
        bidx_s = b0.block_index;
        if (sel == 1) begin
            key_s  = b1.key_out;
            vo_s   = b1.valid_out;
            rdy_s  = b1.ready_in;
            busy_s = b1.busy;
            wrap_s = b1.ctr_wrap;
            bidx_s = b1.block_index;
        end else if (sel == 2) begin
            key_s  = b2.key_out;
            vo_s   = b2.valid_out;
            rdy_s  = b2.ready_in;
            busy_s = b2.busy;
            wrap_s = b2.ctr_wrap;
            bidx_s = b2.block_index;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] key_w(input int i);
        logic [7:0] b;
        b = 8'(4 * i);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr_ref(input logic [31:0] a, b, c, d);
        a += b; d ^= a; d = rl(d, 16);
        c += d; b ^= c; b = rl(b, 12);
        a += b; d ^= a; d = rl(d, 8);
        c += d; b ^= c; b = rl(b, 7);
        return {d, c, b, a};
    endfunction

    // Independent reference: array state, explicit index table per round
    function automatic logic [511:0] ref_block(input logic [31:0] ctr, input int rounds);
        logic [31:0] s [16];
        logic [31:0] x [16];
        logic [511:0] r;
        int idx [8][4];
        int a, b, c, d;
        idx = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e;
        s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = key_w(i);
        s[12] = ctr;
        s[13] = 32'h09000000;
        s[14] = 32'h4a000000;
        s[15] = 32'h00000000;
        x = s;
        for (int rd = 0; rd < rounds; rd++) begin
            for (int g = 0; g < 4; g++) begin
                a = idx[(rd % 2) * 4 + g][0];
                b = idx[(rd % 2) * 4 + g][1];
                c = idx[(rd % 2) * 4 + g][2];
                d = idx[(rd % 2) * 4 + g][3];
                {x[d], x[c], x[b], x[a]} = qr_ref(x[a], x[b], x[c], x[d]);
            end
        end
        for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i] + s[i];
        return r;
    endfunction

    task automatic load(input logic [31:0] ctr, input int nb, input bit cw);
        logic [31:0] w [12];
        for (int i = 0; i < 8; i++) w[i] = key_w(i);
        w[8]  = ctr;
        w[9]  = 32'h09000000;
        w[10] = 32'h4a000000;
        w[11] = 32'h00000000;
        num_blocks = NBW'(nb);
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                valid_in = 1'b0;
                @(posedge clk); #1;
            end
            data_in  = w[i];
            valid_in = 1'b1;
            @(posedge clk); #1;
            if (cw && i == 0) chk("wrap_clr", 512'(wrap_s), 512'(0));
        end
        valid_in = 1'b0;
        chk("rdy_drop", 512'(rdy_s), 512'(0));
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!vo_s && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_tmo", 512'(vo_s), 512'(1));
    endtask

    initial begin
        int n;
        logic [511:0] exp;
        n_tests = 0;
        n_fail = 0;
        sel = 0;
        rst_n = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        num_blocks = NBW'(1);
        ready_out = 1'b1;
        #12;
        chk("rst_rdy", 512'(rdy_s), 512'(1));
        chk("rst_vo", 512'(vo_s), 512'(0));
        chk("rst_key", key_s, 512'(0));
        chk("rst_busy", 512'(busy_s), 512'(0));
        chk("rst_bidx", 512'(bidx_s), 512'(0));
        chk("rst_wrap", 512'(wrap_s), 512'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        load(32'd1, 1, 1'b0);
        wait_valid(n);
        chk("rfc_lat", 512'(n), 512'(21));
        chk("rfc_blk", key_s, RFC_BLK);
        chk("rfc_w0", 512'(key_s[31:0]), 512'(32'he4e7f110));
        chk("rfc_bidx", 512'(bidx_s), 512'(0));
        chk("rfc_busy", 512'(busy_s), 512'(1));
        @(posedge clk); #1;
        chk("rfc_vo_drop", 512'(vo_s), 512'(0));
        chk("rfc_rdy", 512'(rdy_s), 512'(1));
        chk("rfc_idle", 512'(busy_s), 512'(0));

        load(32'd1, 3, 1'b0);
        for (int b = 0; b < 3; b++) begin
            wait_valid(n);
            chk("mb_blk", key_s, ref_block(32'(1 + b), 20));
            chk("mb_bidx", 512'(bidx_s), 512'(b));
            @(posedge clk); #1;
        end
        chk("mb_rdy", 512'(rdy_s), 512'(1));

        ready_out = 1'b0;
        load(32'd7, 2, 1'b0);
        wait_valid(n);
        exp = ref_block(32'd7, 20);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_vo", 512'(vo_s), 512'(1));
            chk("bp_key", key_s, exp);
            chk("bp_bidx", 512'(bidx_s), 512'(0));
        end
        ready_out = 1'b1;
        @(posedge clk); #1;
        wait_valid(n);
        chk("bp_lat", 512'(n), 512'(21));
        chk("bp_blk1", key_s, ref_block(32'd8, 20));
        chk("bp_bidx1", 512'(bidx_s), 512'(1));
        @(posedge clk); #1;

        load(32'hffffffff, 2, 1'b0);
        wait_valid(n);
        chk("wr_blk0", key_s, ref_block(32'hffffffff, 20));
        chk("wr_flag0", 512'(wrap_s), 512'(0));
        @(posedge clk); #1;
        chk("wr_set", 512'(wrap_s), 512'(1));
        wait_valid(n);
        chk("wr_blk1", key_s, ref_block(32'd0, 20));
        chk("wr_bidx1", 512'(bidx_s), 512'(1));
        @(posedge clk); #1;
        chk("wr_sticky", 512'(wrap_s), 512'(1));
        load(32'd1, 1, 1'b1);
        wait_valid(n);
        chk("wr_rfc", key_s, RFC_BLK);
        @(posedge clk); #1;

        sel = 1;
        load(32'd1, 1, 1'b0);
        wait_valid(n);
        chk("c8_lat", 512'(n), 512'(5));
        chk("c8_blk", key_s, ref_block(32'd1, 8));
        @(posedge clk); #1;
        sel = 2;
        load(32'd1, 1, 1'b0);
        wait_valid(n);
        chk("c12_lat", 512'(n), 512'(13));
        chk("c12_blk", key_s, ref_block(32'd1, 12));
        @(posedge clk); #1;
        sel = 0;

        load(32'd1, 1, 1'b0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("rr_busy", 512'(busy_s), 512'(0));
        chk("rr_rdy", 512'(rdy_s), 512'(1));
        chk("rr_vo", 512'(vo_s), 512'(0));
        chk("rr_key", key_s, 512'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        ready_out = 1'b0;
        load(32'd1, 2, 1'b0);
        wait_valid(n);
        rst_n = 1'b0;
        #1;
        chk("ro_vo", 512'(vo_s), 512'(0));
        chk("ro_key", key_s, 512'(0));
        chk("ro_bidx", 512'(bidx_s), 512'(0));
        chk("ro_busy", 512'(busy_s), 512'(0));
        chk("ro_rdy", 512'(rdy_s), 512'(1));
        @(negedge clk) rst_n = 1'b1;
        ready_out = 1'b1;
        @(posedge clk); #1;
        load(32'd1, 1, 1'b0);
        wait_valid(n);
        chk("post_lat", 512'(n), 512'(21));
        chk("post_blk", key_s, RFC_BLK);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
